// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: checks PPU/CPU toggle intervals against expected clk_hdmi ratios.
// Defining CLK_MON_PHASE_EN builds the PPU pixel phase counter; otherwise ppu_phase is 0.
module clk_ratio_monitor #(
  parameter int PPU_DIV = 5,
  parameter int CPU_DIV = 15,
  parameter int TOL = 0,
  parameter int LOCK_N = 8,
  parameter int TIMEOUT = 63
) (
  input  logic        clk_hdmi,
  input  logic        rst,
  input  logic        mmcm_locked,
  input  logic        ppu_tog,
  input  logic        cpu_tog,
  input  logic        err_clr,
  output logic        locked,
  output logic [7:0]  ppu_period,
  output logic [7:0]  cpu_period,
  output logic [15:0] err_count,
  output logic        err_flag,
  output logic [2:0]  ppu_phase
);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam int DIV [2] = '{PPU_DIV, CPU_DIV};
  typedef enum logic [1:0] {WAIT, ACQUIRE, LOCKED} state_t;
  state_t state, state_next;
  logic [1:0] tog, s1, s2, s3, evt, has_ref, meas, good, tmo, bad;
  logic [7:0] cnt [2];
  logic [7:0] period [2];
  logic [GW-1:0] gcnt [2];
  logic [GW-1:0] gcnt_next [2];
  logic active;
  logic [1:0] nerr;
  logic [16:0] err_sum;
  logic [15:0] err_next;
  assign tog = {cpu_tog, ppu_tog};
  assign ppu_period = period[0];
  assign cpu_period = period[1];
  always_comb begin
    evt = s2 ^ s3;
    active = state != WAIT;
    for (int i = 0; i < 2; i++) begin
      meas[i] = active && evt[i] && has_ref[i];
      good[i] = meas[i] && (int'(cnt[i]) - DIV[i] <= TOL) && (DIV[i] - int'(cnt[i]) <= TOL);
      tmo[i] = active && has_ref[i] && !evt[i] && cnt[i] == 8'(TIMEOUT);
      bad[i] = (meas[i] && !good[i]) || tmo[i];
      gcnt_next[i] = (!active || bad[i]) ? '0
                   : (good[i] && gcnt[i] != GW'(LOCK_N)) ? gcnt[i] + GW'(1) : gcnt[i];
    end
    nerr = {1'b0, bad[0]} + {1'b0, bad[1]};
    err_sum = {1'b0, err_count} + 17'(nerr);
    err_next = err_clr ? 16'(nerr) : err_sum[16] ? 16'hFFFF : err_sum[15:0];
    // mmcm loss outranks every other transition
    state_next = state == WAIT ? (mmcm_locked ? ACQUIRE : WAIT)
               : !mmcm_locked ? WAIT
               : (state == ACQUIRE && gcnt_next[0] == GW'(LOCK_N) && gcnt_next[1] == GW'(LOCK_N)) ? LOCKED
               : (state == LOCKED && |bad) ? ACQUIRE : state;
  end
  always_ff @(posedge clk_hdmi) begin
    if (rst) begin
      state <= WAIT;
      locked <= 1'b0;
      {s1, s2, s3, has_ref} <= '0;
      err_count <= '0;
      err_flag <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        period[i] <= '0;
        gcnt[i] <= '0;
      end
    end else begin
      state <= state_next;
      locked <= state == LOCKED;
      s1 <= tog;
      s2 <= s1;
      s3 <= s2;
      err_count <= err_next;
      err_flag <= (err_flag && !err_clr) || |bad;
      for (int i = 0; i < 2; i++) begin
        gcnt[i] <= gcnt_next[i];
        has_ref[i] <= active && (has_ref[i] || evt[i]);
        cnt[i] <= !active ? 8'd0 : (evt[i] || tmo[i]) ? 8'd1 : cnt[i] == 8'hFF ? cnt[i] : cnt[i] + 8'd1;
        if (meas[i]) period[i] <= cnt[i];
        else if (tmo[i]) period[i] <= 8'(TIMEOUT);
      end
    end
  end
`ifdef CLK_MON_PHASE_EN
  logic [2:0] phase;
  always_ff @(posedge clk_hdmi) begin
    if (rst || !active || evt[0]) phase <= '0;
    else phase <= phase == 3'(PPU_DIV - 1) ? 3'd0 : phase + 3'd1;
  end
  assign ppu_phase = phase;
`else
  assign ppu_phase = 3'd0;
`endif
endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: random toggle schedules checked against a timestamp-based reference model.
module tb_clk_ratio_monitor;
  localparam int PPU_DIV = 5, CPU_DIV = 15, TOL = 0, LOCK_N = 8, TIMEOUT = 63;
  logic clk_hdmi = 1'b0, rst = 1'b1, mmcm_locked = 1'b0, ppu_tog = 1'b0, cpu_tog = 1'b0, err_clr = 1'b0;
  logic locked, err_flag;
  logic [7:0] ppu_period, cpu_period;
  logic [15:0] err_count;
  logic [2:0] ppu_phase;
  clk_ratio_monitor dut (
    .clk_hdmi(clk_hdmi), .rst(rst), .mmcm_locked(mmcm_locked), .ppu_tog(ppu_tog), .cpu_tog(cpu_tog),
    .err_clr(err_clr), .locked(locked), .ppu_period(ppu_period), .cpu_period(cpu_period),
    .err_count(err_count), .err_flag(err_flag), .ppu_phase(ppu_phase)
  );
  always #5 clk_hdmi = ~clk_hdmi;
  int vectors = 0, miscompares = 0;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // reference model: event timestamps rather than counters
  int n = 0, mode = 0, m_err = 0, m_pevt = 0, m_phase = 0;
  bit m_flag = 0, m_locked = 0, dut_saw_lock = 0, dut_saw_err = 0;
  bit m_has_ref [2] = '{0, 0};
  int m_ref [2] = '{0, 0};
  int m_good [2] = '{0, 0};
  int m_period [2] = '{0, 0};
  int pq[$], cq[$];
  function automatic int div(input int i);
    return i ? CPU_DIV : PPU_DIV;
  endfunction
  task automatic model_step(input bit r, input bit mm, input bit clr, input bit [1:0] ev);
    int nbad = 0, nmode;
    bit [1:0] bad = 2'b00;
    bit act = mode != 0;
    if (r) begin
      mode = 0; m_locked = 0; m_err = 0; m_flag = 0; m_pevt = n; m_phase = 0;
      for (int i = 0; i < 2; i++) begin
        m_has_ref[i] = 0; m_good[i] = 0; m_period[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int since = n - m_ref[i];
      if (act && ev[i]) begin
        if (m_has_ref[i]) begin
          m_period[i] = since;
          if (since - div(i) <= TOL && div(i) - since <= TOL) m_good[i] = m_good[i] < LOCK_N ? m_good[i] + 1 : LOCK_N;
          else begin bad[i] = 1; m_good[i] = 0; end
        end
        m_has_ref[i] = 1;
        m_ref[i] = n;
      end else if (act && m_has_ref[i] && since == TIMEOUT) begin
        bad[i] = 1; m_good[i] = 0; m_period[i] = TIMEOUT; m_ref[i] = n;
      end
      if (!act) begin m_has_ref[i] = 0; m_good[i] = 0; end
      nbad += int'(bad[i]);
    end
    m_err = clr ? nbad : (m_err + nbad > 65535 ? 65535 : m_err + nbad);
    m_flag = clr ? nbad > 0 : (m_flag || nbad > 0);
    if (!act || ev[0]) m_pevt = n;
    m_phase = (n - m_pevt) % PPU_DIV;
    nmode = mode == 0 ? (mm ? 1 : 0)
          : !mm ? 0
          : (mode == 1 && m_good[0] == LOCK_N && m_good[1] == LOCK_N) ? 2
          : (mode == 2 && bad != 0) ? 1 : mode;
    m_locked = mode == 2;
    mode = nmode;
  endtask
  task automatic tick(input bit r, input bit mm, input bit clr, input bit tp, input bit tc);
    bit [1:0] ev;
    @(negedge clk_hdmi);
    check("locked", int'(locked), int'(m_locked));
    check("ppu_period", int'(ppu_period), m_period[0]);
    check("cpu_period", int'(cpu_period), m_period[1]);
    check("err_count", int'(err_count), m_err);
    check("err_flag", int'(err_flag), int'(m_flag));
`ifdef CLK_MON_PHASE_EN
    check("ppu_phase", int'(ppu_phase), m_phase);
`else
    check("ppu_phase", int'(ppu_phase), 0);
`endif
    if (locked) dut_saw_lock = 1;
    if (err_flag) dut_saw_err = 1;
    rst = r; mmcm_locked = mm; err_clr = clr;
    if (r) begin
      ppu_tog = 0; cpu_tog = 0;
      pq.delete(); cq.delete();
    end else begin
      if (tp) begin ppu_tog = ~ppu_tog; pq.push_back(n); end
      if (tc) begin cpu_tog = ~cpu_tog; cq.push_back(n); end
    end
    // a toggle launched in cycle k shows up as an event in cycle k+2
    ev[0] = pq.size() > 0 && pq[0] + 2 == n;
    ev[1] = cq.size() > 0 && cq[0] + 2 == n;
    if (ev[0]) void'(pq.pop_front());
    if (ev[1]) void'(cq.pop_front());
    model_step(r, mm, clr, ev);
    n++;
  endtask
  function automatic int next_iv(input int i, input int kind);
    int d = div(i);
    int r = $urandom_range(0, 7);
    if (kind == 1 && r == 0) return d + $urandom_range(1, 2);
    if (kind == 1 && r == 1) return d - 1;
    if (kind == 3 && r < 2) return d - 1;
    return d;
  endfunction
  initial begin
    int kind, len;
    int cd [2];
    bit mm, r, clr, stop;
    bit [1:0] t;
    cd = '{1, 1};
    repeat (3) tick(1, 0, 0, 0, 0);
    repeat (4) tick(0, 0, 0, 0, 0);
    // kinds: 0 nominal, 1 glitches, 2 stopped cpu, 3 simultaneous errors + clears, 4 mmcm drop, 5 reset, 6 stopped ppu
    for (int seg = 0; seg < 24; seg++) begin
      kind = seg == 0 ? 0 : $urandom_range(0, 6);
      len = $urandom_range(200, 400);
      for (int c = 0; c < len; c++) begin
        mm = !(kind == 4 && c >= 50 && c < 90);
        r = kind == 5 && c == 20;
        clr = $urandom_range(0, kind == 3 ? 3 : 40) == 0;
        for (int i = 0; i < 2; i++) begin
          stop = (kind == 2 && i == 1 && c >= 30 && c < 230) || (kind == 6 && i == 0 && c >= 30 && c < 130);
          t[i] = 0;
          if (!stop) begin
            cd[i]--;
            if (cd[i] <= 0) begin t[i] = 1; cd[i] = next_iv(i, kind); end
          end
        end
        tick(r, mm, clr, t[0], t[1]);
      end
    end
    tick(0, 1, 0, 0, 0);
    check("saw_lock", int'(dut_saw_lock), 1);
    check("saw_err", int'(dut_saw_err), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
